// File: rtl/systolic_pkg.sv
// Shared types and constants for the weight-stationary systolic array.
package systolic_pkg;

  localparam int DATA_W      = 8;
  localparam int N_DEF       = 4;
  localparam int COMPUTE_LEN = 3 * N_DEF;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LOAD,
    COMPUTE,
    FINISH
  } state_t;

  function automatic int compute_len(input int n);
    return 3 * n;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: stationary weight, pass-right activation,
// multiply-accumulate on the psum travelling down the column.
module systolic_pe #(
  parameter int DATA_W = systolic_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     compute,
  input  logic signed [DATA_W-1:0] w_left,
  input  logic signed [DATA_W-1:0] a_left,
  input  logic signed [DATA_W-1:0] psum_up,
  output logic signed [DATA_W-1:0] w_right,
  output logic signed [DATA_W-1:0] a_right,
  output logic signed [DATA_W-1:0] psum_down
);

  logic signed [DATA_W-1:0] w_p0;
  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] psum_p0;

  // Product and sum both wrap modulo 2^DATA_W.
  function automatic logic signed [DATA_W-1:0] mac_wrap(
    input logic signed [DATA_W-1:0] acc,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] w
  );
    logic signed [DATA_W-1:0] prod;
    prod = a * w;
    return acc + prod;
  endfunction

  // Stage p0: weight shift during load, mac and activation pass during compute
  always_ff @(posedge clk) begin
    if (rst) begin
      w_p0    <= '0;
      a_p0    <= '0;
      psum_p0 <= '0;
    end else if (load) begin
      w_p0    <= w_left;
      a_p0    <= '0;
      psum_p0 <= '0;
    end else if (compute) begin
      a_p0    <= a_left;
      psum_p0 <= mac_wrap(psum_up, a_left, w_p0);
    end
  end

  assign w_right   = w_p0;
  assign a_right   = a_p0;
  assign psum_down = psum_p0;

endmodule

// File: rtl/systolic_array.sv
// NxN weight-stationary systolic array computing Y = X*W, framed by a
// start/ready/done handshake; weights shift in, activations stream skewed.
module systolic_array #(
  parameter int N      = systolic_pkg::N_DEF,
  parameter int DATA_W = systolic_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in  [N],
  input  logic [DATA_W-1:0] w_in  [N],
  output logic [DATA_W-1:0] y_out [N],
  output logic              ready,
  output logic              done
);

  import systolic_pkg::*;

  localparam int CLEN  = compute_len(N);
  localparam int CNT_W = $clog2(CLEN);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               compute;

  logic signed [DATA_W-1:0] w_bus [N][N];
  logic signed [DATA_W-1:0] a_bus [N][N];
  logic signed [DATA_W-1:0] p_bus [N][N];

  assign load    = (state == LOAD);
  assign compute = (state == COMPUTE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= WAIT;
            ready <= 1'b0;
          end
        end
        // Absorbs the pop latency of the external feeder FIFOs.
        WAIT: begin
          state <= LOAD;
          cnt   <= '0;
        end
        LOAD: begin
          if (cnt == CNT_W'(N - 1)) begin
            state <= COMPUTE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMPUTE: begin
          if (cnt == CNT_W'(CLEN - 1)) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic signed [DATA_W-1:0] w_src;
      logic signed [DATA_W-1:0] a_src;
      logic signed [DATA_W-1:0] p_src;

      if (c == 0) begin : g_edge_l
        assign w_src = w_in[k];
        assign a_src = a_in[k];
      end else begin : g_inner_l
        assign w_src = w_bus[k][c-1];
        assign a_src = a_bus[k][c-1];
      end

      if (k == 0) begin : g_edge_t
        assign p_src = '0;
      end else begin : g_inner_t
        assign p_src = p_bus[k-1][c];
      end

      systolic_pe #(.DATA_W(DATA_W)) u_pe (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .compute   (compute),
        .w_left    (w_src),
        .a_left    (a_src),
        .psum_up   (p_src),
        .w_right   (w_bus[k][c]),
        .a_right   (a_bus[k][c]),
        .psum_down (p_bus[k][c])
      );
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_out
    assign y_out[c] = p_bus[N-1][c];
  end

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: drives skewed jobs and checks every
// output value at its expected cycle plus the handshake.
module tb_systolic_array;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a_in  [N];
  logic [7:0] w_in  [N];
  logic [7:0] y_out [N];
  logic       ready;
  logic       done;

  logic [7:0] wm [N][N];
  logic [7:0] xm [N][N];
  logic [7:0] ym [N][N];

  int checks;
  int errors;

  systolic_array #(.N(N), .DATA_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .w_in  (w_in),
    .y_out (y_out),
    .ready (ready),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_nominal();
    logic [7:0] a_tab [N][N];
    a_tab = '{'{8'd4, 8'd0, 8'd2, 8'd1},
              '{8'd4, 8'd3, 8'd2, 8'd0},
              '{8'd4, 8'd3, 8'd0, 8'd1},
              '{8'd4, 8'd3, 8'd2, 8'd1}};
    ym = '{'{8'd16, 8'd32, 8'd48, 8'd64},
           '{8'd9,  8'd18, 8'd27, 8'd36},
           '{8'd6,  8'd12, 8'd18, 8'd24},
           '{8'd3,  8'd6,  8'd9,  8'd12}};
    for (int k = 0; k < N; k++)
      for (int c = 0; c < N; c++) begin
        wm[k][c] = 8'(c + 1);
        xm[c][k] = a_tab[k][c];
      end
  endtask

  // Runs one job; abort_e >= 0 asserts rst at that compute edge.
  task automatic run_job(input string name, input int abort_e, input bit poke);
    int m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, " ready_low"}, 32'(ready), 32'd0);
    @(posedge clk); #1;
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) w_in[k] = wm[k][N-1-j];
      if (poke && j == 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int k = 0; k < N; k++) w_in[k] = 8'd0;
    for (int e = 0; e < 3 * N; e++) begin
      for (int k = 0; k < N; k++) begin
        a_in[k] = 8'd0;
        if (e - k >= 0 && e - k < N) a_in[k] = xm[e-k][k];
      end
      if (poke && e == 3) start = 1'b1;
      if (e == abort_e) rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (e == abort_e) begin
        rst = 1'b0;
        for (int k = 0; k < N; k++) a_in[k] = 8'd0;
        chk({name, " abort_ready"}, 32'(ready), 32'd1);
        chk({name, " abort_done"}, 32'(done), 32'd0);
        for (int c = 0; c < N; c++)
          chk($sformatf("%s abort_y c%0d", name, c), 32'(y_out[c]), 32'd0);
        return;
      end
      for (int c = 0; c < N; c++) begin
        m = e - c - N + 1;
        if (m >= 0 && m < N)
          chk($sformatf("%s y m%0d c%0d", name, m, c), 32'(y_out[c]), 32'(ym[m][c]));
      end
      chk($sformatf("%s done e%0d", name, e), 32'(done), (e == 3 * N - 1) ? 32'd1 : 32'd0);
      chk($sformatf("%s busy e%0d", name, e), 32'(ready), 32'd0);
    end
    for (int k = 0; k < N; k++) a_in[k] = 8'd0;
    @(posedge clk); #1;
    chk({name, " done_drop"}, 32'(done), 32'd0);
    chk({name, " ready_back"}, 32'(ready), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    for (int k = 0; k < N; k++) begin
      a_in[k] = 8'd0;
      w_in[k] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset done", 32'(done), 32'd0);
    for (int c = 0; c < N; c++)
      chk($sformatf("reset y c%0d", c), 32'(y_out[c]), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("idle hold ready", 32'(ready), 32'd1);
    chk("idle hold done", 32'(done), 32'd0);

    set_nominal();
    run_job("nominal", -1, 1'b0);

    for (int k = 0; k < N; k++)
      for (int c = 0; c < N; c++) begin
        wm[k][c] = 8'd255;
        xm[k][c] = 8'd255;
        ym[k][c] = 8'd4;
      end
    run_job("overflow", -1, 1'b0);

    for (int k = 0; k < N; k++)
      for (int c = 0; c < N; c++) begin
        wm[k][c] = (k == c) ? 8'd1 : 8'd0;
        xm[k][c] = 8'(10 * k + c);
        ym[k][c] = 8'(10 * k + c);
      end
    run_job("identity", -1, 1'b0);

    set_nominal();
    run_job("poke", -1, 1'b1);
    run_job("abort", 5, 1'b0);
    run_job("after_abort", -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_array.md
Name: systolic_array

Overview:
- NxN weight-stationary systolic array that computes Y = X·W on 8-bit data, one output row per pass.
- Weights are shifted in once per job, then activation rows stream through skewed; partial sums flow down the columns.
- External per-row feeder FIFOs drive a_in/w_in and capture y_out; those FIFOs sit outside this block.
- A start/ready/done handshake frames each job.

Parameters:
- N, 4, array dimension (rows = columns = N).
- DATA_W, 8, width of activations, weights and outputs.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request; honoured only while ready=1.
- a_in[0:N-1]  in  N x DATA_W  activation input per array row k.
- w_in[0:N-1]  in  N x DATA_W  weight input per array row k.
- y_out[0:N-1]  out  N x DATA_W  result per column c (bottom PE psum register).
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset clears all PE weight, activation and psum registers and sets y_out=0, ready=1, done=0.
- Reset mid-job aborts the job and returns the block to IDLE.
- FSM is IDLE → WAIT → LOAD → COMPUTE → FINISH → IDLE.
- IDLE: ready=1. start=1 at edge S moves the FSM to WAIT. start outside IDLE is ignored.
- WAIT: lasts 1 cycle (edge S+1) and absorbs the external pop latency of the first-word-fall-through FIFOs.
- LOAD: runs on the N edges S+2..S+N+1.
  - On each edge, PE(k,0) captures w_in[k] and each PE(k,c) passes its weight to PE(k,c+1).
  - Input order per row is W[k][N-1] first, down to W[k][0] last, so PE(k,c) ends holding W[k][c].
  - a_in is ignored; activation and psum registers are held at 0.
- COMPUTE: lasts 3N cycles. Compute edges are numbered e=0..3N-1.
  - On each edge, PE(k,0) latches a_in[k]; activations shift right one PE per edge.
  - PE(k,c) registers psum = psum_from_PE(k-1,c) + a·W[k][c]. Row 0 uses 0 as the incoming psum.
- Input contract: X[m][k] is presented on a_in[k] at compute edge m+k. a_in is 0 outside those edges.
- Output timing: Y[m][c] = Σk X[m][k]·W[k][c], valid on y_out[c] for exactly the one cycle after compute edge m+c+N-1.
- Arithmetic: products and sums are truncated to DATA_W bits, i.e. modulo 2^DATA_W.
- FINISH: done=1 for 1 cycle, then IDLE (ready=1). Weights are retained until the next LOAD.
- Weights are reloaded on every job.
- y_out keeps driving the bottom psum registers in all states.
- Empty FIFOs present 0, and zero inputs are harmless.

Decomposition:
- Package systolic_pkg: DATA_W, the state enum (IDLE, WAIT, LOAD, COMPUTE, FINISH), and the compute-length constant 3*N.
- Sub-module systolic_pe holds the weight register (shift-in/shift-out), the activation register (pass-right) and the psum register (mac, pass-down).
- Top level: generate loop over the NxN grid plus the FSM/counter.

Test Plan:
- Reset → ready=1, done=0, all y_out=0. start held 0 → state stays IDLE.
- Nominal job: W rows all = {1,2,3,4}. X[m][k] = A[k][m] with A rows {4,0,2,1},{4,3,2,0},{4,3,0,1},{4,3,2,1}.
  - Expected Y rows: {16,32,48,64}, {9,18,27,36}, {6,12,18,24}, {3,6,9,12}.
  - Each value at its skewed cycle; done pulses once after the 3N compute cycles.
- Overflow: all X=255, all W=255 → every Y = 4 (mod 256).
- Identity weights (W[k][c] = 1 when k=c, else 0) with X[m][k] = 10m+k → Y[m][c] = 10m+c.
- start pulsed during LOAD/COMPUTE → ignored; results unchanged; exactly one done pulse.
- rst asserted mid-COMPUTE → next cycle ready=1, y_out=0. A fresh job afterwards gives the nominal results.
